// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
//   Peripheral write port of the 7-segment scan controller.
//   master: bus side. It drives the write strobe and the staged digit data, and it
//           reads the pending flag.
//   slave : the controller. It samples the write and drives the pending flag.
// Signals
//   wr_en     one-cycle write strobe
//   wr_data   hex nibbles, digit 0 in bits [3:0]
//   wr_dp     decimal-point enables, one per digit
//   wr_blank  per-digit blank mask (1 = digit dark)
//   pend      a staged write is waiting for the next frame boundary
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    wr_en;
  logic [4*NUM_DIGITS-1:0] wr_data;
  logic [NUM_DIGITS-1:0]   wr_dp;
  logic [NUM_DIGITS-1:0]   wr_blank;
  logic                    pend;

  modport master (output wr_en, wr_data, wr_dp, wr_blank, input pend);
  modport slave  (input wr_en, wr_data, wr_dp, wr_blank, output pend);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a common-anode 7-segment bank.
//   Each digit gets a dark BLANK gap followed by a lit SHOW slot. The gap
//   suppresses ghosting. Writes from the bus are staged and become visible
//   only at a frame boundary, so a frame never mixes old and new digits.
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   scan_en    1 = scan, 0 = display dark and scan parked at digit 0
//   bus        write port (slave modport): wr_en/wr_data/wr_dp/wr_blank in, pend out
//   an         digit enables, active low, at most one low at a time
//   seg        {a,b,c,d,e,f,g,dp}, active low
//   frame_tick one-cycle pulse on the first BLANK cycle of each frame
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_en,
  seg_scan_ctrl_if.slave        bus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;

  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic [4*NUM_DIGITS-1:0] stg_data;
  logic [NUM_DIGITS-1:0]   stg_dp;
  logic [NUM_DIGITS-1:0]   stg_blank;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   sel_an;
  logic [7:0]              seg_pat;
  logic [NUM_DIGITS-1:0]   show_an;
  logic [7:0]              show_seg;
  logic                    frame_end;
  logic                    commit;

  // Hex to active-low segments with the decimal point off.
  function automatic logic [7:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 8'h03;
      4'h1: decode = 8'h9F;
      4'h2: decode = 8'h25;
      4'h3: decode = 8'h0D;
      4'h4: decode = 8'h99;
      4'h5: decode = 8'h49;
      4'h6: decode = 8'h41;
      4'h7: decode = 8'h1F;
      4'h8: decode = 8'h01;
      4'h9: decode = 8'h09;
      4'hA: decode = 8'h11;
      4'hB: decode = 8'hC1;
      4'hC: decode = 8'h63;
      4'hD: decode = 8'h85;
      4'hE: decode = 8'h61;
      default: decode = 8'h71;
    endcase
  endfunction

  // Pick the current digit's fields from the display registers. A loop is used
  // instead of a variable index so that a non-power-of-two NUM_DIGITS stays clean.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    sel_an    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = disp_data[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = disp_blank[i];
        sel_an[i] = 1'b0;
      end
    end
    seg_pat = decode(cur_nib);
    if (cur_blank) begin
      show_an  = '1;
      show_seg = 8'hFF;
    end else begin
      show_an  = sel_an;
      show_seg = {seg_pat[7:1], ~cur_dp};
    end
  end

  // A pending write commits at the last digit's SHOW->BLANK edge. It also
  // commits whenever scanning is stopped, because the display is dark then.
  assign frame_end = (state == SHOW) && (cnt == SHOW_LAST) && (idx == LAST_IDX);
  assign commit    = bus.pend && (!scan_en || frame_end);

  // Scan FSM. an/seg are loaded on the edge that enters or stays in a state,
  // so they always line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      an         <= '1;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
    end else if (!scan_en) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      an         <= '1;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
            an    <= show_an;
            seg   <= show_seg;
          end else begin
            cnt <= cnt + 1'b1;
            an  <= '1;
            seg <= 8'hFF;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            an    <= '1;
            seg   <= 8'hFF;
            if (idx == LAST_IDX) begin
              idx        <= '0;
              frame_tick <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
            an  <= show_an;
            seg <= show_seg;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
          an    <= '1;
          seg   <= 8'hFF;
        end
      endcase
    end
  end

  // Staging and display registers. The commit reads the old staged value, so a
  // write on the commit edge is staged for the following frame and keeps pend set.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blank <= '1;
      stg_data   <= '0;
      stg_dp     <= '0;
      stg_blank  <= '0;
      bus.pend   <= 1'b0;
    end else begin
      if (commit) begin
        disp_data  <= stg_data;
        disp_dp    <= stg_dp;
        disp_blank <= stg_blank;
        bus.pend   <= 1'b0;
      end
      if (bus.wr_en) begin
        stg_data  <= bus.wr_data;
        stg_dp    <= bus.wr_dp;
        stg_blank <= bus.wr_blank;
        bus.pend  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1.
//   Cycle 0 is the period that follows the edge that sampled reset. A frame is
//   20 cycles long: cycle 0 is BLANK d0, cycles 1-4 are SHOW d0, cycle 5 is
//   BLANK d1, and so on. Outputs are sampled 1 time unit after the rising edge.
module tb_seg_scan_ctrl;

  localparam int ND = 4;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       scan_en = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame_tick;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(4),
    .BLANK_CYC  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .bus       (bus.slave),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
    end
  endtask

  // Stage a write. It is sampled on the edge that ends the current cycle.
  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank);
    bus.wr_en    = 1'b1;
    bus.wr_data  = data;
    bus.wr_dp    = dp;
    bus.wr_blank = blank;
  endtask

  // Advance one clock and drop the write strobe.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
    bus.wr_en = 1'b0;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) nextCycle();
  endtask

  task automatic startFromReset();
    reset     = 1'b1;
    scan_en   = 1'b1;
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Check an and seg for every cycle of one SHOW slot.
  task automatic checkDigit(input string tag, input int first, input int last,
                            input logic [3:0] expAn, input logic [7:0] expSeg);
    for (int c = first; c <= last; c++) begin
      runTo(c);
      checkOutput({tag, "_an"}, 16'(an), 16'(expAn));
      checkOutput({tag, "_seg"}, 16'(seg), 16'(expSeg));
    end
  endtask

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.wr_dp    = '0;
    bus.wr_blank = '0;

    // Idle after reset: dark display, frame ticks at 20 and 40, nothing pending.
    startFromReset();
    for (int c = 0; c <= 40; c++) begin
      runTo(c);
      checkOutput("idle_an", 16'(an), 16'hF);
      checkOutput("idle_seg", 16'(seg), 16'hFF);
      checkOutput("idle_tick", 16'(frame_tick), 16'((c == 20) || (c == 40)));
      checkOutput("idle_pend", 16'(bus.pend), 16'h0);
    end

    // The first write commits at the frame boundary.
    startFromReset();
    runTo(2);
    applyStimulus(16'h1234, 4'b0000, 4'b0000);
    runTo(3);
    checkOutput("wr_pend_early", 16'(bus.pend), 16'h1);
    checkOutput("wr_an_still_dark", 16'(an), 16'hF);
    runTo(19);
    checkOutput("wr_pend_late", 16'(bus.pend), 16'h1);
    runTo(20);
    checkOutput("commit_tick", 16'(frame_tick), 16'h1);
    checkOutput("commit_pend", 16'(bus.pend), 16'h0);
    checkOutput("commit_an", 16'(an), 16'hF);
    checkDigit("f1_d0", 21, 24, 4'b1110, 8'h99);
    runTo(25);
    checkOutput("gap_an", 16'(an), 16'hF);
    checkOutput("gap_tick", 16'(frame_tick), 16'h0);
    // A mid-frame write must not disturb the frame that is showing.
    applyStimulus(16'hABCD, 4'b0001, 4'b0100);
    checkDigit("f1_d1", 26, 29, 4'b1101, 8'h0D);
    checkDigit("f1_d2", 31, 34, 4'b1011, 8'h25);
    checkDigit("f1_d3", 36, 39, 4'b0111, 8'h9F);
    runTo(40);
    checkOutput("f2_tick", 16'(frame_tick), 16'h1);
    checkOutput("f2_pend", 16'(bus.pend), 16'h0);
    checkDigit("f2_d0_dp", 41, 44, 4'b1110, 8'h84);
    runTo(45);
    applyStimulus(16'h9E0F, 4'b0000, 4'b0000);
    runTo(46);
    checkOutput("f2_pend_again", 16'(bus.pend), 16'h1);
    checkDigit("f2_d1", 46, 49, 4'b1101, 8'h63);
    checkDigit("f2_d2_blank", 51, 54, 4'b1111, 8'hFF);
    checkDigit("f2_d3", 56, 59, 4'b0111, 8'h11);
    // A write on the commit edge is staged for the next frame.
    applyStimulus(16'hB876, 4'b0000, 4'b0000);
    runTo(60);
    checkOutput("f3_tick", 16'(frame_tick), 16'h1);
    checkOutput("f3_pend_kept", 16'(bus.pend), 16'h1);
    checkDigit("f3_d0", 61, 64, 4'b1110, 8'h71);
    checkDigit("f3_d1", 66, 69, 4'b1101, 8'h03);
    checkDigit("f3_d2", 71, 74, 4'b1011, 8'h61);
    checkDigit("f3_d3", 76, 79, 4'b0111, 8'h09);
    runTo(80);
    checkOutput("f4_tick", 16'(frame_tick), 16'h1);
    checkOutput("f4_pend", 16'(bus.pend), 16'h0);
    checkDigit("f4_d0", 81, 84, 4'b1110, 8'h41);
    checkDigit("f4_d1", 86, 89, 4'b1101, 8'h1F);
    checkDigit("f4_d2", 91, 94, 4'b1011, 8'h01);
    checkDigit("f4_d3", 96, 99, 4'b0111, 8'hC1);

    // Dropping scan_en mid-SHOW darkens the display and commits the pending write.
    startFromReset();
    runTo(2);
    applyStimulus(16'h1234, 4'b0000, 4'b0000);
    runTo(22);
    applyStimulus(16'h00F5, 4'b0000, 4'b0000);
    runTo(23);
    checkOutput("se_pend", 16'(bus.pend), 16'h1);
    checkOutput("se_an_before", 16'(an), 16'hE);
    checkOutput("se_seg_before", 16'(seg), 16'h99);
    scan_en = 1'b0;
    runTo(24);
    checkOutput("se_off_an", 16'(an), 16'hF);
    checkOutput("se_off_seg", 16'(seg), 16'hFF);
    checkOutput("se_off_pend", 16'(bus.pend), 16'h0);
    checkOutput("se_off_tick", 16'(frame_tick), 16'h0);
    runTo(25);
    checkOutput("se_off_an2", 16'(an), 16'hF);
    checkOutput("se_off_tick2", 16'(frame_tick), 16'h0);
    runTo(26);
    scan_en = 1'b1;
    checkOutput("se_restart_blank", 16'(an), 16'hF);
    checkDigit("se_d0", 27, 30, 4'b1110, 8'h49);
    runTo(31);
    checkOutput("se_gap", 16'(an), 16'hF);
    checkDigit("se_d1", 32, 35, 4'b1101, 8'h71);

    // A reset during SHOW of digit 2 discards the pending write and blanks the display.
    startFromReset();
    runTo(2);
    applyStimulus(16'h1234, 4'b0000, 4'b0000);
    runTo(30);
    applyStimulus(16'h5555, 4'b0000, 4'b0000);
    runTo(31);
    checkOutput("rst_pre_pend", 16'(bus.pend), 16'h1);
    checkOutput("rst_pre_an", 16'(an), 16'hB);
    checkOutput("rst_pre_seg", 16'(seg), 16'h25);
    runTo(32);
    reset = 1'b1;
    runTo(33);
    checkOutput("rst_an", 16'(an), 16'hF);
    checkOutput("rst_seg", 16'(seg), 16'hFF);
    checkOutput("rst_pend", 16'(bus.pend), 16'h0);
    checkOutput("rst_tick", 16'(frame_tick), 16'h0);
    reset = 1'b0;
    for (int c = 34; c <= 53; c++) begin
      runTo(c);
      checkOutput("post_rst_an", 16'(an), 16'hF);
      checkOutput("post_rst_tick", 16'(frame_tick), 16'(c == 53));
    end
    checkOutput("post_rst_pend", 16'(bus.pend), 16'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
